// File: rtl/dma_pcie_mi_64Bx128_32Bwe_ram_if.sv
// ---------------------------------------------------------------------------
// dma_pcie_mi_64Bx128_32Bwe_ram_if
//   Bundle for one 64 B x 128-entry simple-dual-port memory-instance RAM
//   with two 32 B write enables, per-byte parity and ECC status on read.
//
//   Write side : wen[1:0] (bit0 = bytes 0..31), wadr, wdat, wpar (even
//                parity per byte, bit i covers wdat[8i+7:8i]).
//   Read side  : ren, radr; rdat/rpar/rsbe/rdbe valid RD_LAT cycles
//                after ren.
//   Modport m  : arbiter side (drives controls, receives read data).
//   Modport s  : RAM side.
// ---------------------------------------------------------------------------
interface dma_pcie_mi_64Bx128_32Bwe_ram_if;
  logic [1:0]   wen;
  logic [6:0]   wadr;
  logic [511:0] wdat;
  logic [63:0]  wpar;
  logic         ren;
  logic [6:0]   radr;
  logic [511:0] rdat;
  logic [63:0]  rpar;
  logic         rsbe;
  logic         rdbe;

  modport m (
    output wen, wadr, wdat, wpar, ren, radr,
    input  rdat, rpar, rsbe, rdbe
  );

  modport s (
    input  wen, wadr, wdat, wpar, ren, radr,
    output rdat, rpar, rsbe, rdbe
  );
endinterface

// File: rtl/dma_pcie_mi_ram_arb.sv
// ---------------------------------------------------------------------------
// dma_pcie_mi_ram_arb
//   Two-writer / two-reader arbiter and sequencer in front of one
//   64 B x 128 simple-dual-port RAM with 32 B write enables.
//
//   Each port is arbitrated independently with a two-way round-robin: a lone
//   requester wins, on contention the requester not granted most recently
//   wins. Grants are combinational; accepted requests are registered onto
//   the RAM the following cycle. Write parity is generated per byte. A read
//   whose address matches the write being granted in the same cycle is held
//   off one cycle so it returns the freshly written data. Read responses are
//   tagged with the reader id and returned in grant order; ECC and parity
//   status is counted (saturating) and latched into sticky flags.
//
//   Parameters
//     RD_LAT    RAM read latency, ren -> rdat valid (1..4)
//     CNT_W     width of the saturating error counters
//
//   Ports
//     clk, rst_n                     clock, async active-low reset
//     wr_req/wr_adr*/wr_be*/wr_dat*  writer requests (held until granted)
//     wr_gnt                         one-hot write grant
//     rd_req/rd_adr*                 reader requests (held until granted)
//     rd_gnt                         one-hot read grant
//     rsp_vld/rsp_id/rsp_dat         read response
//     rsp_sbe/rsp_dbe/rsp_perr       response status flags
//     err_clr                        clears counters and sticky flags
//     sbe_cnt/dbe_cnt/perr_cnt       saturating event counters
//     err_sticky                     {perr, dbe, sbe} seen since last clear
//     ram                            RAM master modport
// ---------------------------------------------------------------------------
module dma_pcie_mi_ram_arb #(
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic [1:0]       wr_req,
  input  logic [6:0]       wr_adr0,
  input  logic [6:0]       wr_adr1,
  input  logic [1:0]       wr_be0,
  input  logic [1:0]       wr_be1,
  input  logic [511:0]     wr_dat0,
  input  logic [511:0]     wr_dat1,
  output logic [1:0]       wr_gnt,

  input  logic [1:0]       rd_req,
  input  logic [6:0]       rd_adr0,
  input  logic [6:0]       rd_adr1,
  output logic [1:0]       rd_gnt,

  output logic             rsp_vld,
  output logic             rsp_id,
  output logic [511:0]     rsp_dat,
  output logic             rsp_sbe,
  output logic             rsp_dbe,
  output logic             rsp_perr,

  input  logic             err_clr,
  output logic [CNT_W-1:0] sbe_cnt,
  output logic [CNT_W-1:0] dbe_cnt,
  output logic [CNT_W-1:0] perr_cnt,
  output logic [2:0]       err_sticky,

  dma_pcie_mi_64Bx128_32Bwe_ram_if.m ram
);

  // Read-tag carried alongside the RAM read latency.
  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  // Even parity per byte: bit i covers d[8i+7:8i].
  function automatic logic [63:0] byte_par(input logic [511:0] d);
    logic [63:0] p;
    for (int i = 0; i < 64; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

  // Two-way round-robin pick; 'last' is the most recently granted index.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    return (req == 2'b11) ? ~last : req[1];
  endfunction

  // -------------------------------------------------------------------------
  // Arbitration (combinational)
  // -------------------------------------------------------------------------
  logic         wr_last;
  logic         rd_last;

  logic         wr_any;
  logic         wr_sel;
  logic [6:0]   wr_adr_sel;
  logic [1:0]   wr_be_sel;
  logic [511:0] wr_dat_sel;

  logic         rd_any;
  logic         rd_sel;
  logic [6:0]   rd_adr_sel;
  logic         rd_blk;
  logic         rd_go;

  logic         rd_par_err;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (here unconditionally), otherwise synthesis infers a latch.
  always_comb begin
    wr_any     = |wr_req;
    wr_sel     = rr_pick(wr_req, wr_last);
    wr_adr_sel = wr_sel ? wr_adr1 : wr_adr0;
    wr_be_sel  = wr_sel ? wr_be1  : wr_be0;
    wr_dat_sel = wr_sel ? wr_dat1 : wr_dat0;

    rd_any     = |rd_req;
    rd_sel     = rr_pick(rd_req, rd_last);
    rd_adr_sel = rd_sel ? rd_adr1 : rd_adr0;

    // Same-address read during a granted write would see stale data on a
    // simple-dual-port RAM; defer it one cycle instead. The read pointer is
    // untouched, so the same reader wins again next cycle.
    rd_blk     = wr_any && (rd_adr_sel == wr_adr_sel);
    rd_go      = rd_any && !rd_blk;

    wr_gnt     = wr_any ? (wr_sel ? 2'b10 : 2'b01) : 2'b00;
    rd_gnt     = rd_go  ? (rd_sel ? 2'b10 : 2'b01) : 2'b00;

    rd_par_err = |(byte_par(ram.rdat) ^ ram.rpar);
  end

  // -------------------------------------------------------------------------
  // Write path: registered onto the RAM the cycle after the grant.
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_last  <= 1'b1;
      ram.wen  <= 2'b00;
      ram.wadr <= '0;
      ram.wdat <= '0;
      ram.wpar <= '0;
    end else if (wr_any) begin
      wr_last  <= wr_sel;
      ram.wen  <= wr_be_sel;        // be == 0 is a granted no-op
      ram.wadr <= wr_adr_sel;
      ram.wdat <= wr_dat_sel;
      ram.wpar <= byte_par(wr_dat_sel);
    end else begin
      ram.wen  <= 2'b00;            // address/data/parity hold
    end
  end

  // -------------------------------------------------------------------------
  // Read path and tag pipeline
  //   tag_q[0] is aligned with ren, tag_q[RD_LAT] with valid RAM read data.
  // -------------------------------------------------------------------------
  tag_t tag_q [RD_LAT+1];

  // NOTE: the tag pipeline is a handful of flops and is reset so that reads
  // in flight at reset are discarded; the RAM array itself is never reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_last  <= 1'b1;
      ram.ren  <= 1'b0;
      ram.radr <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ram.ren <= rd_go;
      if (rd_go) begin
        rd_last  <= rd_sel;
        ram.radr <= rd_adr_sel;
      end
      tag_q[0] <= '{vld: rd_go, id: rd_sel};
      for (int i = 1; i <= RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Response register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld  <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_dat  <= '0;
      rsp_sbe  <= 1'b0;
      rsp_dbe  <= 1'b0;
      rsp_perr <= 1'b0;
    end else begin
      rsp_vld <= tag_q[RD_LAT].vld;
      if (tag_q[RD_LAT].vld) begin
        rsp_id   <= tag_q[RD_LAT].id;
        rsp_dat  <= ram.rdat;
        rsp_sbe  <= ram.rsbe;
        rsp_dbe  <= ram.rdbe;
        rsp_perr <= rd_par_err;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Error accounting: clear has priority over a same-cycle event.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbe_cnt    <= '0;
      dbe_cnt    <= '0;
      perr_cnt   <= '0;
      err_sticky <= 3'b000;
    end else if (err_clr) begin
      sbe_cnt    <= '0;
      dbe_cnt    <= '0;
      perr_cnt   <= '0;
      err_sticky <= 3'b000;
    end else if (rsp_vld) begin
      if (rsp_sbe) begin
        if (sbe_cnt != '1) sbe_cnt <= sbe_cnt + 1'b1;
        err_sticky[0] <= 1'b1;
      end
      if (rsp_dbe) begin
        if (dbe_cnt != '1) dbe_cnt <= dbe_cnt + 1'b1;
        err_sticky[1] <= 1'b1;
      end
      if (rsp_perr) begin
        if (perr_cnt != '1) perr_cnt <= perr_cnt + 1'b1;
        err_sticky[2] <= 1'b1;
      end
    end
  end

endmodule
